// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - fetch/decode/execute controller for a registered 4-bit ALU
module alu_sequencer #(
    parameter int PC_W     = 4,
    parameter int START_PC = 0
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic            Start,
    output logic            Busy,
    output logic            Done,
    output logic [PC_W-1:0] Imem_addr,
    output logic            Imem_rd,
    input  logic [9:0]      Imem_data,
    output logic [3:0]      Alu_a,
    output logic [3:0]      Alu_b,
    output logic [3:0]      Alu_opc,
    input  logic [3:0]      Alu_out,
    input  logic            Alu_z,
    output logic [3:0]      Acc,
    output logic [PC_W-1:0] Pc
);
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_DONE
    } state_t;

    localparam logic [3:0]      OPC_PASS_A = 4'b0011;
    localparam logic [PC_W-1:0] START      = PC_W'(START_PC);
    localparam logic [1:0]      CL_ALU     = 2'b00;
    localparam logic [1:0]      CL_JZ      = 2'b01;
    localparam logic [1:0]      CL_JMP     = 2'b10;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [3:0]      acc_q, acc_d;
    logic [3:0]      opc_q, opc_d;
    logic [3:0]      b_q, b_d;
    logic            zf_q, zf_d;
    logic [1:0]      cls;
    logic [PC_W-1:0] jmp_tgt;
    logic [PC_W-1:0] pc_inc;

    assign cls     = Imem_data[9:8];
    assign jmp_tgt = PC_W'(Imem_data[3:0]);
    assign pc_inc  = pc_q + PC_W'(1);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (Start) state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (cls)
                    CL_ALU:  state_d = S_EXEC;
                    CL_JZ,
                    CL_JMP:  state_d = S_FETCH;
                    default: state_d = S_DONE;
                endcase
            end
            S_EXEC:   state_d = S_WB;
            S_WB:     state_d = S_FETCH;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        Busy    = (state_q != S_IDLE);
        Done    = (state_q == S_DONE);
        Imem_rd = (state_q == S_FETCH);
    end

    // ALU operand registers load only when entering EXEC; opcode drops back
    // to pass-A after WB so the free-running ALU just mirrors ACC.
    always_comb begin
        pc_d  = pc_q;
        acc_d = acc_q;
        zf_d  = zf_q;
        opc_d = opc_q;
        b_d   = b_q;
        case (state_q)
            S_IDLE: begin
                if (Start) pc_d = START;
            end
            S_DECODE: begin
                case (cls)
                    CL_ALU: begin
                        opc_d = Imem_data[7:4];
                        b_d   = Imem_data[3:0];
                    end
                    CL_JZ:   pc_d = zf_q ? jmp_tgt : pc_inc;
                    CL_JMP:  pc_d = jmp_tgt;
                    default: pc_d = pc_q;
                endcase
            end
            S_WB: begin
                acc_d = Alu_out;
                zf_d  = Alu_z;
                pc_d  = pc_inc;
                opc_d = OPC_PASS_A;
            end
            default: pc_d = pc_q;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            pc_q  <= START;
            acc_q <= 4'd0;
            zf_q  <= 1'b0;
            opc_q <= OPC_PASS_A;
            b_q   <= 4'd0;
        end else begin
            pc_q  <= pc_d;
            acc_q <= acc_d;
            zf_q  <= zf_d;
            opc_q <= opc_d;
            b_q   <= b_d;
        end
    end

    assign Imem_addr = pc_q;
    assign Pc        = pc_q;
    assign Acc       = acc_q;
    assign Alu_a     = acc_q;
    assign Alu_b     = b_q;
    assign Alu_opc   = opc_q;
endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - scoreboard bench for alu_sequencer with ROM and ALU models
module tb_alu_sequencer;
    typedef struct {
        logic [3:0] acc;
        logic [3:0] pc;
        int         lat;
    } exp_t;

    logic clk, rst, start_a, start_b;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic       busy_a, done_a, imem_rd_a, alu_z_a;
    logic [3:0] imem_addr_a, alu_a_a, alu_b_a, alu_opc_a, alu_out_a, acc_a, pc_a;
    logic [9:0] imem_data_a;
    logic [9:0] rom_a [16];

    logic       busy_b, done_b, imem_rd_b, alu_z_b;
    logic [1:0] imem_addr_b, pc_b;
    logic [3:0] alu_a_b, alu_b_b, alu_opc_b, alu_out_b, acc_b;
    logic [9:0] imem_data_b;
    logic [9:0] rom_b [4];

    exp_t       q_a[$];
    exp_t       q_b[$];
    logic [1:0] fetched_b[$];
    int         launches_a = 0, dones_a = 0, launches_b = 0, dones_b = 0;
    int         launch_cyc_a = 0, launch_cyc_b = 0;
    int         forbid_lo = 16, forbid_hi = 0;

    alu_sequencer #(.PC_W(4), .START_PC(0)) dut_a (
        .Clk(clk), .Rst(rst), .Start(start_a), .Busy(busy_a), .Done(done_a),
        .Imem_addr(imem_addr_a), .Imem_rd(imem_rd_a), .Imem_data(imem_data_a),
        .Alu_a(alu_a_a), .Alu_b(alu_b_a), .Alu_opc(alu_opc_a),
        .Alu_out(alu_out_a), .Alu_z(alu_z_a), .Acc(acc_a), .Pc(pc_a)
    );

    alu_sequencer #(.PC_W(2), .START_PC(3)) dut_b (
        .Clk(clk), .Rst(rst), .Start(start_b), .Busy(busy_b), .Done(done_b),
        .Imem_addr(imem_addr_b), .Imem_rd(imem_rd_b), .Imem_data(imem_data_b),
        .Alu_a(alu_a_b), .Alu_b(alu_b_b), .Alu_opc(alu_opc_b),
        .Alu_out(alu_out_b), .Alu_z(alu_z_b), .Acc(acc_b), .Pc(pc_b)
    );

    function automatic logic [3:0] alu_f(input logic [3:0] opc, input logic [3:0] a,
                                         input logic [3:0] b);
        case (opc)
            4'h0:    return b;
            4'h1:    return a + b;
            4'h2:    return a - b;
            4'h3:    return a;
            4'h4:    return a & b;
            4'h5:    return a | b;
            4'h6:    return a ^ b;
            4'h7:    return ~a;
            default: return a + 4'd1;
        endcase
    endfunction

    always @(posedge clk) begin
        cyc       <= cyc + 1;
        alu_out_a <= alu_f(alu_opc_a, alu_a_a, alu_b_a);
        alu_out_b <= alu_f(alu_opc_b, alu_a_b, alu_b_b);
        if (imem_rd_a) imem_data_a <= rom_a[imem_addr_a];
        if (imem_rd_b) imem_data_b <= rom_b[imem_addr_b];
    end
    assign alu_z_a = (alu_out_a == 4'd0);
    assign alu_z_b = (alu_out_b == 4'd0);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: scores every Done pulse against the oldest pending expectation
    always @(negedge clk) begin
        exp_t e;
        if (imem_rd_a) begin
            check("fetch_opc_pass_a", alu_opc_a, 4'b0011);
            if (forbid_lo <= forbid_hi)
                check("skipped_not_fetched",
                      (int'(imem_addr_a) >= forbid_lo && int'(imem_addr_a) <= forbid_hi), 0);
        end
        if (imem_rd_b) fetched_b.push_back(imem_addr_b);
        if (launches_a != dones_a) check("busy_a_during_run", busy_a, 1);
        if (launches_b != dones_b) check("busy_b_during_run", busy_b, 1);
        if (done_a) begin
            if (q_a.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done_a: got Done=1 expected no pulse (acc %0d)", acc_a);
            end else begin
                e = q_a.pop_front();
                check("done_acc_a", acc_a, e.acc);
                check("done_pc_a", pc_a, e.pc);
                check("done_latency_a", cyc - launch_cyc_a + 1, e.lat);
                dones_a++;
            end
        end
        if (done_b) begin
            if (q_b.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done_b: got Done=1 expected no pulse (acc %0d)", acc_b);
            end else begin
                e = q_b.pop_front();
                check("done_acc_b", acc_b, e.acc);
                check("done_pc_b", pc_b, e.pc);
                check("done_latency_b", cyc - launch_cyc_b + 1, e.lat);
                dones_b++;
            end
        end
    end

    // Latency counts the cycle in which Start is sampled as cycle 1
    task automatic launch_a(input logic [3:0] acc, input logic [3:0] pc, input int lat,
                            input bit track);
        exp_t e;
        @(negedge clk);
        start_a = 1'b1;
        if (track) begin
            launch_cyc_a = cyc;
            e.acc = acc; e.pc = pc; e.lat = lat;
            q_a.push_back(e);
        end
        @(posedge clk);
        #1 if (track) launches_a++;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic wait_done_a(input string name);
        int n = 0;
        while (dones_a != launches_a && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL %s_timeout: got no Done expected Done within 200 cycles", name);
        end
        repeat (20) @(negedge clk);
    endtask

    task automatic load_t1();
        for (int i = 0; i < 16; i++) rom_a[i] = 10'b11_0000_0000;
        rom_a[0] = 10'b00_0000_0101;
        rom_a[1] = 10'b00_0001_0011;
        rom_a[2] = 10'b11_0000_0000;
    endtask

    initial begin
        exp_t e;
        int   n;
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
        for (int i = 0; i < 4; i++) rom_b[i] = 10'b00_0000_1111;
        load_t1();
        repeat (3) @(negedge clk);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_imem_rd", imem_rd_a, 0);
        check("rst_acc", acc_a, 0);
        check("rst_pc", pc_a, 0);
        check("rst_alu_opc", alu_opc_a, 4'b0011);
        check("rst_pc_b", pc_b, 3);
        @(negedge clk);
        rst = 1'b0;

        // T4: two-bit PC starting at 3 wraps to 0 after the load
        rom_b[3] = 10'b00_0000_1001;
        rom_b[0] = 10'b11_0000_0000;
        @(negedge clk);
        start_b = 1'b1;
        launch_cyc_b = cyc;
        e.acc = 4'd9; e.pc = 4'd0; e.lat = 8;
        q_b.push_back(e);
        @(posedge clk);
        #1 launches_b++;
        @(negedge clk);
        start_b = 1'b0;
        n = 0;
        while (dones_b != launches_b && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL t4_timeout: got no Done expected Done within 200 cycles");
        end
        repeat (5) @(negedge clk);
        check("t4_fetch_count", fetched_b.size(), 2);
        if (fetched_b.size() >= 2) begin
            check("t4_first_fetch", fetched_b[0], 3);
            check("t4_wrap_fetch", fetched_b[1], 0);
        end

        // T1: LD5, ADD3, HALT
        launch_a(4'd8, 4'd2, 12, 1'b1);
        wait_done_a("t1");

        // T2: LD5, SUB5, JZ 6 taken, words 3..5 must never be fetched
        for (int i = 0; i < 16; i++) rom_a[i] = 10'b00_0000_1111;
        rom_a[0] = 10'b00_0000_0101;
        rom_a[1] = 10'b00_0010_0101;
        rom_a[2] = 10'b01_0000_0110;
        rom_a[6] = 10'b11_0000_0000;
        forbid_lo = 3; forbid_hi = 5;
        launch_a(4'd0, 4'd6, 14, 1'b1);
        wait_done_a("t2");
        forbid_lo = 16; forbid_hi = 0;

        // T3: LD1 clears ZF, JZ falls through to HALT at 2
        rom_a[0] = 10'b00_0000_0001;
        rom_a[1] = 10'b01_0000_0110;
        rom_a[2] = 10'b11_0000_0000;
        launch_a(4'd1, 4'd2, 10, 1'b1);
        wait_done_a("t3");

        // T6: a second Start mid-run is ignored
        load_t1();
        launch_a(4'd8, 4'd2, 12, 1'b1);
        repeat (4) @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_done_a("t6");

        // T5: reset during EXEC of ADD aborts with no Done
        launch_a(4'd0, 4'd0, 0, 1'b0);
        n = 0;
        while (alu_opc_a != 4'b0001 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("t5_reached_exec", alu_opc_a, 4'b0001);
        check("t5_acc_before", acc_a, 5);
        rst = 1'b1;
        @(negedge clk);
        check("t5_busy", busy_a, 0);
        check("t5_acc", acc_a, 0);
        check("t5_pc", pc_a, 0);
        check("t5_imem_rd", imem_rd_a, 0);
        check("t5_done", done_a, 0);
        check("t5_alu_opc", alu_opc_a, 4'b0011);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        check("queue_a_drained", q_a.size(), 0);
        check("queue_b_drained", q_b.size(), 0);
        check("done_count_a", dones_a, 4);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got still running expected finish");
        $fatal(1, "timeout");
    end
endmodule
